// File: rtl/vx_interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller (IRQC) and its TTU interface.
package vx_interrupt_controller_pkg;

  typedef enum logic [2:0] {
    IRQC_IDLE        = 3'd0,
    IRQC_WAIT        = 3'd1,
    IRQC_PC_SWAP     = 3'd2,
    IRQC_WAIT_ISR    = 3'd3,
    IRQC_REVERT_WARP = 3'd4
  } irqc_state_t;

  localparam logic [1:0] IRQC_RESP_OK        = 2'd0;
  localparam logic [1:0] IRQC_RESP_NOT_FOUND = 2'd1;
  localparam logic [1:0] IRQC_RESP_TIMEOUT   = 2'd2;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_interrupt_controller_if.sv
// IRQC <-> thread transfer unit (TTU) bus; the IRQC drives the master side.
interface vx_interrupt_controller_if
  import vx_interrupt_controller_pkg::*;
#(
  parameter int unsigned THREAD_CNT     = 4,
  parameter int unsigned WARP_CNT       = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned WARP_CNT_WIDTH = log2up(WARP_CNT),
  parameter int unsigned TID_WIDTH      = log2up(THREAD_CNT)
) ();

  irqc_state_t               state;
  logic [WARP_CNT_WIDTH-1:0] wid;
  logic [TID_WIDTH-1:0]      tid;
  logic [XLEN-1:0]           load_pc;
  logic [THREAD_CNT-1:0]     load_tmask;
  logic [WARP_CNT-1:0]       load_wmask;
  logic [XLEN-1:0]           rha;

  logic                      pipeline_drained;
  logic                      thread_found;
  logic [XLEN-1:0]           current_pc;
  logic [THREAD_CNT-1:0]     current_thread_mask;
  logic [WARP_CNT-1:0]       current_active_warps;
  logic                      isr_done;

  modport master (
    output state, wid, tid, load_pc, load_tmask, load_wmask, rha,
    input  pipeline_drained, thread_found, current_pc, current_thread_mask,
           current_active_warps, isr_done
  );

  modport slave (
    input  state, wid, tid, load_pc, load_tmask, load_wmask, rha,
    output pipeline_drained, thread_found, current_pc, current_thread_mask,
           current_active_warps, isr_done
  );

endinterface

// File: rtl/vx_irqc_resp_buf.sv
// One-entry valid/ready register slice holding the IRQC completion response.
module vx_irqc_resp_buf #(
  parameter int unsigned WID_W = 2,
  parameter int unsigned TID_W = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [1:0]       push_status_i,
  input  logic [WID_W-1:0] push_wid_i,
  input  logic [TID_W-1:0] push_tid_i,
  input  logic [XLEN-1:0]  push_pc_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [1:0]       status_o,
  output logic [WID_W-1:0] wid_o,
  output logic [TID_W-1:0] tid_o,
  output logic [XLEN-1:0]  pc_o
);

  logic             valid_q, valid_d;
  logic [1:0]       status_q, status_d;
  logic [WID_W-1:0] wid_q, wid_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic [XLEN-1:0]  pc_q, pc_d;

  // The FSM only pushes while the slice is empty, so push never collides with a held entry.
  always_comb begin
    valid_d  = valid_q;
    status_d = status_q;
    wid_d    = wid_q;
    tid_d    = tid_q;
    pc_d     = pc_q;
    if (push_i) begin
      valid_d  = 1'b1;
      status_d = push_status_i;
      wid_d    = push_wid_i;
      tid_d    = push_tid_i;
      pc_d     = push_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d  = 1'b0;
      status_d = '0;
      wid_d    = '0;
      tid_d    = '0;
      pc_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      status_q <= '0;
      wid_q    <= '0;
      tid_q    <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      status_q <= status_d;
      wid_q    <= wid_d;
      tid_q    <= tid_d;
      pc_q     <= pc_d;
    end
  end

  assign valid_o  = valid_q;
  assign status_o = status_q;
  assign wid_o    = wid_q;
  assign tid_o    = tid_q;
  assign pc_o     = pc_q;

endmodule

// File: rtl/vx_interrupt_controller.sv
// Interrupt controller: pulls one thread out of a warp via the TTU, runs the ISR on it,
// restores the warp and reports the thread's resume PC to the scalar core.
module vx_interrupt_controller
  import vx_interrupt_controller_pkg::*;
#(
  parameter int unsigned THREAD_CNT     = 4,
  parameter int unsigned WARP_CNT       = 4,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned WAIT_TIMEOUT   = 1024,
  parameter int unsigned WARP_CNT_WIDTH = log2up(WARP_CNT),
  parameter int unsigned TID_WIDTH      = log2up(THREAD_CNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      irq_valid_i,
  output logic                      irq_ready_o,
  input  logic [WARP_CNT_WIDTH-1:0] irq_wid_i,
  input  logic [TID_WIDTH-1:0]      irq_tid_i,
  input  logic [XLEN-1:0]           irq_isr_pc_i,
  input  logic [XLEN-1:0]           irq_rha_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [1:0]                resp_status_o,
  output logic [WARP_CNT_WIDTH-1:0] resp_wid_o,
  output logic [TID_WIDTH-1:0]      resp_tid_o,
  output logic [XLEN-1:0]           resp_pc_o,
  output logic [31:0]               perf_irq_served_o,
  vx_interrupt_controller_if.master ttu_if
);

  localparam int unsigned CntW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  irqc_state_t               state_q, state_d;
  logic [WARP_CNT_WIDTH-1:0] wid_q, wid_d;
  logic [TID_WIDTH-1:0]      tid_q, tid_d;
  logic [XLEN-1:0]           isr_pc_q, isr_pc_d;
  logic [XLEN-1:0]           rha_q, rha_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [XLEN-1:0]           cap_pc_q, cap_pc_d;
  logic [THREAD_CNT-1:0]     cap_tmask_q, cap_tmask_d;
  logic [WARP_CNT-1:0]       cap_wmask_q, cap_wmask_d;
  logic [31:0]               perf_q, perf_d;

  logic                      push;
  logic [1:0]                push_status;
  logic [XLEN-1:0]           push_pc;

  assign irq_ready_o = (state_q == IRQC_IDLE) && !resp_valid_o;

  always_comb begin
    state_d     = state_q;
    wid_d       = wid_q;
    tid_d       = tid_q;
    isr_pc_d    = isr_pc_q;
    rha_d       = rha_q;
    cnt_d       = cnt_q;
    cap_pc_d    = cap_pc_q;
    cap_tmask_d = cap_tmask_q;
    cap_wmask_d = cap_wmask_q;
    perf_d      = perf_q;
    push        = 1'b0;
    push_status = IRQC_RESP_OK;
    push_pc     = '0;
    unique case (state_q)
      IRQC_IDLE: begin
        if (irq_valid_i && irq_ready_o) begin
          wid_d    = irq_wid_i;
          tid_d    = irq_tid_i;
          isr_pc_d = irq_isr_pc_i;
          rha_d    = irq_rha_i;
          cnt_d    = '0;
          if ((32'(irq_wid_i) >= WARP_CNT) || (32'(irq_tid_i) >= THREAD_CNT)) begin
            push        = 1'b1;
            push_status = IRQC_RESP_NOT_FOUND;
          end else begin
            state_d = IRQC_WAIT;
          end
        end
      end
      IRQC_WAIT: begin
        // A drained+found result outranks a timeout landing in the same cycle.
        if (ttu_if.pipeline_drained && ttu_if.thread_found) begin
          cap_pc_d    = ttu_if.current_pc;
          cap_tmask_d = ttu_if.current_thread_mask;
          cap_wmask_d = ttu_if.current_active_warps;
          state_d     = IRQC_PC_SWAP;
        end else if (ttu_if.pipeline_drained) begin
          push        = 1'b1;
          push_status = IRQC_RESP_NOT_FOUND;
          state_d     = IRQC_IDLE;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CntMax)) begin
          push        = 1'b1;
          push_status = IRQC_RESP_TIMEOUT;
          state_d     = IRQC_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      IRQC_PC_SWAP: state_d = IRQC_WAIT_ISR;
      IRQC_WAIT_ISR: begin
        if (ttu_if.isr_done) state_d = IRQC_REVERT_WARP;
      end
      IRQC_REVERT_WARP: begin
        push        = 1'b1;
        push_status = IRQC_RESP_OK;
        push_pc     = cap_pc_q;
        if (perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
        state_d     = IRQC_IDLE;
      end
      default: state_d = IRQC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IRQC_IDLE;
      wid_q       <= '0;
      tid_q       <= '0;
      isr_pc_q    <= '0;
      rha_q       <= '0;
      cnt_q       <= '0;
      cap_pc_q    <= '0;
      cap_tmask_q <= '0;
      cap_wmask_q <= '0;
      perf_q      <= '0;
    end else begin
      state_q     <= state_d;
      wid_q       <= wid_d;
      tid_q       <= tid_d;
      isr_pc_q    <= isr_pc_d;
      rha_q       <= rha_d;
      cnt_q       <= cnt_d;
      cap_pc_q    <= cap_pc_d;
      cap_tmask_q <= cap_tmask_d;
      cap_wmask_q <= cap_wmask_d;
      perf_q      <= perf_d;
    end
  end

  // load_pc keeps isr_pc through WAIT_ISR: the TTU matches the ISR-exit jump against it.
  always_comb begin
    ttu_if.state      = state_q;
    ttu_if.wid        = wid_q;
    ttu_if.tid        = tid_q;
    ttu_if.rha        = rha_q;
    ttu_if.load_pc    = '0;
    ttu_if.load_tmask = '0;
    ttu_if.load_wmask = '0;
    unique case (state_q)
      IRQC_PC_SWAP, IRQC_WAIT_ISR: ttu_if.load_pc = isr_pc_q;
      IRQC_REVERT_WARP: begin
        ttu_if.load_pc    = cap_pc_q;
        ttu_if.load_tmask = cap_tmask_q;
        ttu_if.load_wmask = cap_wmask_q;
      end
      default: ;
    endcase
  end

  assign perf_irq_served_o = perf_q;

  vx_irqc_resp_buf #(
    .WID_W (WARP_CNT_WIDTH),
    .TID_W (TID_WIDTH),
    .XLEN  (XLEN)
  ) u_resp_buf (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .push_status_i (push_status),
    .push_wid_i    (wid_d),
    .push_tid_i    (tid_d),
    .push_pc_i     (push_pc),
    .ready_i       (resp_ready_i),
    .valid_o       (resp_valid_o),
    .status_o      (resp_status_o),
    .wid_o         (resp_wid_o),
    .tid_o         (resp_tid_o),
    .pc_o          (resp_pc_o)
  );

endmodule

// File: tb/tb_vx_interrupt_controller.sv
// Scenario bench for vx_interrupt_controller; responses checked against a scoreboard queue.
module tb_vx_interrupt_controller;
  import vx_interrupt_controller_pkg::*;

  localparam int unsigned THREAD_CNT   = 6;
  localparam int unsigned WARP_CNT     = 4;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned WAIT_TIMEOUT = 8;
  localparam int unsigned WW           = 2;
  localparam int unsigned TW           = 3;

  typedef struct packed {
    logic [1:0]    status;
    logic [WW-1:0] wid;
    logic [TW-1:0] tid;
    logic [31:0]   pc;
  } resp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            irq_valid = 1'b0;
  logic            irq_ready;
  logic [WW-1:0]   irq_wid = '0;
  logic [TW-1:0]   irq_tid = '0;
  logic [31:0]     irq_isr_pc = '0;
  logic [31:0]     irq_rha = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_status;
  logic [WW-1:0]   resp_wid;
  logic [TW-1:0]   resp_tid;
  logic [31:0]     resp_pc;
  logic [31:0]     perf;

  resp_t exp_q[$];
  resp_t mon_got, mon_exp;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  vx_interrupt_controller_if #(
    .THREAD_CNT (THREAD_CNT),
    .WARP_CNT   (WARP_CNT),
    .XLEN       (XLEN)
  ) ttu ();

  vx_interrupt_controller #(
    .THREAD_CNT   (THREAD_CNT),
    .WARP_CNT     (WARP_CNT),
    .XLEN         (XLEN),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .irq_valid_i       (irq_valid),
    .irq_ready_o       (irq_ready),
    .irq_wid_i         (irq_wid),
    .irq_tid_i         (irq_tid),
    .irq_isr_pc_i      (irq_isr_pc),
    .irq_rha_i         (irq_rha),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_status_o     (resp_status),
    .resp_wid_o        (resp_wid),
    .resp_tid_o        (resp_tid),
    .resp_pc_o         (resp_pc),
    .perf_irq_served_o (perf),
    .ttu_if            (ttu)
  );

  // Scoreboard: every response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      mon_got = {resp_status, resp_wid, resp_tid, resp_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %h required none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL resp_fields: got %h required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WW-1:0] w, input logic [TW-1:0] t,
                       input logic [31:0] isr, input logic [31:0] rha);
    irq_valid  = 1'b1;
    irq_wid    = w;
    irq_tid    = t;
    irq_isr_pc = isr;
    irq_rha    = rha;
    tick();
    irq_valid  = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic ttu_idle();
    ttu.pipeline_drained     = 1'b0;
    ttu.thread_found         = 1'b0;
    ttu.current_pc           = '0;
    ttu.current_thread_mask  = '0;
    ttu.current_active_warps = '0;
    ttu.isr_done             = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({ttu.state, resp_valid, irq_ready, perf} !== {IRQC_IDLE, 1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", {ttu.state, resp_valid, irq_ready, perf},
               {IRQC_IDLE, 1'b0, 1'b1, 32'd0});
    end
    checks++;
    if ({ttu.load_pc, ttu.load_tmask, ttu.load_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_loads: got %h required 0", {ttu.load_pc, ttu.load_tmask, ttu.load_wmask});
    end
  endtask

  task automatic test_ok_path();
    checks++;
    if (irq_ready !== 1'b1) begin
      errors++;
      $display("FAIL ok_ready: got %b required 1", irq_ready);
    end
    exp_q.push_back({IRQC_RESP_OK, 2'd1, 3'd2, 32'h8000_0040});
    issue(2'd1, 3'd2, 32'h8000_0100, 32'h8000_0800);
    checks++;
    if ({ttu.state, ttu.wid, ttu.tid, ttu.rha} !== {IRQC_WAIT, 2'd1, 3'd2, 32'h8000_0800}) begin
      errors++;
      $display("FAIL ok_wait: got %h required %h", {ttu.state, ttu.wid, ttu.tid, ttu.rha},
               {IRQC_WAIT, 2'd1, 3'd2, 32'h8000_0800});
    end
    for (int i = 0; i < 4; i++) tick();
    ttu.pipeline_drained     = 1'b1;
    ttu.thread_found         = 1'b1;
    ttu.current_pc           = 32'h8000_0040;
    ttu.current_thread_mask  = 6'b001111;
    ttu.current_active_warps = 4'b0011;
    tick();
    ttu_idle();
    checks++;
    if ({ttu.state, ttu.load_pc, ttu.load_tmask} !== {IRQC_PC_SWAP, 32'h8000_0100, 6'd0}) begin
      errors++;
      $display("FAIL ok_pc_swap: got %h required %h", {ttu.state, ttu.load_pc, ttu.load_tmask},
               {IRQC_PC_SWAP, 32'h8000_0100, 6'd0});
    end
    tick();
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if ({ttu.state, ttu.load_pc} !== {IRQC_WAIT_ISR, 32'h8000_0100}) begin
      errors++;
      $display("FAIL ok_wait_isr: got %h required %h", {ttu.state, ttu.load_pc},
               {IRQC_WAIT_ISR, 32'h8000_0100});
    end
    ttu.isr_done = 1'b1;
    tick();
    ttu.isr_done = 1'b0;
    checks++;
    if ({ttu.state, ttu.load_pc, ttu.load_tmask, ttu.load_wmask, resp_valid} !==
        {IRQC_REVERT_WARP, 32'h8000_0040, 6'b001111, 4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL ok_revert: got %h required %h",
               {ttu.state, ttu.load_pc, ttu.load_tmask, ttu.load_wmask, resp_valid},
               {IRQC_REVERT_WARP, 32'h8000_0040, 6'b001111, 4'b0011, 1'b0});
    end
    tick();
    checks++;
    if ({resp_valid, ttu.state, perf} !== {1'b1, IRQC_IDLE, 32'd1}) begin
      errors++;
      $display("FAIL ok_resp: got %h required %h", {resp_valid, ttu.state, perf},
               {1'b1, IRQC_IDLE, 32'd1});
    end
    handshake();
    checks++;
    if ({resp_valid, resp_pc, irq_ready} !== {1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL ok_cleared: got %h required %h", {resp_valid, resp_pc, irq_ready},
               {1'b0, 32'd0, 1'b1});
    end
  endtask

  task automatic test_not_found();
    exp_q.push_back({IRQC_RESP_NOT_FOUND, 2'd2, 3'd1, 32'd0});
    issue(2'd2, 3'd1, 32'h8000_0200, 32'h0);
    tick();
    checks++;
    if (ttu.state !== IRQC_WAIT) begin
      errors++;
      $display("FAIL nf_wait2: got %0d required %0d", ttu.state, IRQC_WAIT);
    end
    ttu.pipeline_drained = 1'b1;
    tick();
    ttu_idle();
    checks++;
    if ({ttu.state, resp_valid} !== {IRQC_IDLE, 1'b1}) begin
      errors++;
      $display("FAIL nf_resp: got %h required %h", {ttu.state, resp_valid}, {IRQC_IDLE, 1'b1});
    end
    handshake();
  endtask

  task automatic test_timeout();
    int n;
    exp_q.push_back({IRQC_RESP_TIMEOUT, 2'd0, 3'd5, 32'd0});
    issue(2'd0, 3'd5, 32'h8000_0300, 32'h0);
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL to_latency: got %0d required 8", n);
    end
    handshake();
    // Drained+found arrives in the same cycle the counter would expire.
    exp_q.push_back({IRQC_RESP_OK, 2'd3, 3'd0, 32'h1234_5678});
    issue(2'd3, 3'd0, 32'h8000_0400, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    ttu.pipeline_drained     = 1'b1;
    ttu.thread_found         = 1'b1;
    ttu.current_pc           = 32'h1234_5678;
    ttu.current_thread_mask  = 6'b000011;
    ttu.current_active_warps = 4'b1000;
    tick();
    ttu_idle();
    checks++;
    if ({ttu.state, resp_valid} !== {IRQC_PC_SWAP, 1'b0}) begin
      errors++;
      $display("FAIL to_race_swap: got %h required %h", {ttu.state, resp_valid},
               {IRQC_PC_SWAP, 1'b0});
    end
    tick();
    ttu.isr_done = 1'b1;
    tick();
    ttu.isr_done = 1'b0;
    checks++;
    if ({ttu.load_pc, ttu.load_tmask, ttu.load_wmask} !== {32'h1234_5678, 6'b000011, 4'b1000})
    begin
      errors++;
      $display("FAIL to_race_revert: got %h required %h",
               {ttu.load_pc, ttu.load_tmask, ttu.load_wmask}, {32'h1234_5678, 6'b000011, 4'b1000});
    end
    tick();
    handshake();
    checks++;
    if (perf !== 32'd2) begin
      errors++;
      $display("FAIL to_perf: got %0d required 2", perf);
    end
  endtask

  task automatic test_backpressure();
    int n;
    exp_q.push_back({IRQC_RESP_NOT_FOUND, 2'd0, 3'd7, 32'd0});
    issue(2'd0, 3'd7, 32'h8000_0500, 32'h0);
    irq_valid  = 1'b1;
    irq_wid    = 2'd1;
    irq_tid    = 3'd0;
    irq_isr_pc = 32'h8000_0600;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({resp_valid, resp_status, resp_wid, resp_tid, resp_pc, irq_ready, ttu.state} !==
          {1'b1, IRQC_RESP_NOT_FOUND, 2'd0, 3'd7, 32'd0, 1'b0, IRQC_IDLE}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h required %h", i,
                 {resp_valid, resp_status, resp_wid, resp_tid, resp_pc, irq_ready, ttu.state},
                 {1'b1, IRQC_RESP_NOT_FOUND, 2'd0, 3'd7, 32'd0, 1'b0, IRQC_IDLE});
      end
      tick();
    end
    handshake();
    checks++;
    if ({resp_valid, irq_ready, ttu.state} !== {1'b0, 1'b1, IRQC_IDLE}) begin
      errors++;
      $display("FAIL bp_release: got %h required %h", {resp_valid, irq_ready, ttu.state},
               {1'b0, 1'b1, IRQC_IDLE});
    end
    exp_q.push_back({IRQC_RESP_TIMEOUT, 2'd1, 3'd0, 32'd0});
    tick();
    irq_valid = 1'b0;
    checks++;
    if ({ttu.state, ttu.wid} !== {IRQC_WAIT, 2'd1}) begin
      errors++;
      $display("FAIL bp_second: got %h required %h", {ttu.state, ttu.wid}, {IRQC_WAIT, 2'd1});
    end
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    handshake();
  endtask

  task automatic test_range();
    exp_q.push_back({IRQC_RESP_NOT_FOUND, 2'd0, 3'd6, 32'd0});
    issue(2'd0, 3'd6, 32'h8000_0700, 32'h0);
    checks++;
    if ({resp_valid, ttu.state} !== {1'b1, IRQC_IDLE}) begin
      errors++;
      $display("FAIL range_nf: got %h required %h", {resp_valid, ttu.state}, {1'b1, IRQC_IDLE});
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(2'd2, 3'd3, 32'h8000_0900, 32'h0);
    ttu.pipeline_drained = 1'b1;
    ttu.thread_found     = 1'b1;
    ttu.current_pc       = 32'hDEAD_0000;
    tick();
    ttu_idle();
    tick();
    tick();
    checks++;
    if (ttu.state !== IRQC_WAIT_ISR) begin
      errors++;
      $display("FAIL rst_mid_pre: got %0d required %0d", ttu.state, IRQC_WAIT_ISR);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ttu.state, resp_valid, irq_ready, perf, ttu.load_pc} !==
        {IRQC_IDLE, 1'b0, 1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL rst_mid: got %h required %h", {ttu.state, resp_valid, irq_ready, perf, ttu.load_pc},
               {IRQC_IDLE, 1'b0, 1'b1, 32'd0, 32'd0});
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_silent: got %b required 0", resp_valid);
    end
  endtask

  initial begin
    ttu_idle();
    test_reset();
    test_ok_path();
    test_not_found();
    test_timeout();
    test_backpressure();
    test_range();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
